// File: rtl/cache_arb_pkg.sv
// Shared types and helpers for the two-port cache arbiter.
package cache_arb_pkg;

    // Transaction sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arb_state_e;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    // Width of a counter that must hold every value 0..max without wrapping.
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

    // Watchdog counter width for the default TIMEOUT of 255.
    localparam int unsigned WD_W_DEFAULT = cnt_width(255);

endpackage

// File: rtl/cache_port_arbiter_if.sv
// Bundle of requester (I/D) and cache-side signals around the arbiter.
interface cache_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    // Instruction-fetch requester
    logic              IReq;
    logic [ADDR_W-1:0] IAddr;
    logic              IGnt;
    logic              IValid;
    logic [DATA_W-1:0] IRData;

    // Data-memory requester
    logic              DReq;
    logic              DWE;
    logic [ADDR_W-1:0] DAddr;
    logic [DATA_W-1:0] DWData;
    logic              DGnt;
    logic              DValid;
    logic [DATA_W-1:0] DRData;

    // Cache controls and status
    logic              CStart;
    logic              CWriteEnable;
    logic [ADDR_W-1:0] CAddr;
    logic [DATA_W-1:0] CWData;
    logic [DATA_W-1:0] CRData;
    logic              CReadReady;
    logic              CWriteReady;

    logic              Timeout;

    // Arbiter side
    modport slave (
        input  IReq, IAddr, DReq, DWE, DAddr, DWData,
        input  CRData, CReadReady, CWriteReady,
        output IGnt, IValid, IRData, DGnt, DValid, DRData,
        output CStart, CWriteEnable, CAddr, CWData, Timeout
    );

    // Environment side (requesters plus cache)
    modport master (
        output IReq, IAddr, DReq, DWE, DAddr, DWData,
        output CRData, CReadReady, CWriteReady,
        input  IGnt, IValid, IRData, DGnt, DValid, DRData,
        input  CStart, CWriteEnable, CAddr, CWData, Timeout
    );

endinterface

// File: rtl/cache_arb_select.sv
// Winner selection between I and D with starvation protection for I.
module cache_arb_select
    import cache_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic   clk_i,
    input  logic   rst_ni,
    input  logic   ireq_i,
    input  logic   dreq_i,
    input  logic   arb_en_i,
    output owner_e owner_o,
    output logic   any_req_o
);

    localparam int unsigned SW = cnt_width(STARVE_MAX);

    logic [SW-1:0] starve_q, starve_d;
    logic          contested;
    logic          starved;

    assign contested = ireq_i && dreq_i;
    assign starved   = (starve_q == SW'(STARVE_MAX));
    assign any_req_o = ireq_i || dreq_i;

    // D wins contention unless I has lost STARVE_MAX contested rounds in a row.
    always_comb begin
        owner_o = OWN_D;
        if (ireq_i && (!dreq_i || starved)) begin
            owner_o = OWN_I;
        end
    end

    // Count contested D wins; any I grant clears the count.
    always_comb begin
        starve_d = starve_q;
        if (arb_en_i && any_req_o) begin
            if (owner_o == OWN_I) begin
                starve_d = '0;
            end else if (contested && !starved) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares one cache between the I and D requesters: arbitrate, issue one
// cache transaction, wait for its ready flag (or the watchdog), respond.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                CLK,
    input  logic                Reset,
    cache_port_arbiter_if.slave bus
);

    localparam int unsigned WD_W = cnt_width(TIMEOUT);

    arb_state_e        st_q, st_d;
    owner_e            owner_q, owner_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              to_q, to_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [DATA_W-1:0] ird_q, ird_d;
    logic [DATA_W-1:0] drd_q, drd_d;

    owner_e            sel_owner;
    logic              any_req;
    logic              arb_en;
    logic              done;
    logic [WD_W-1:0]   wd_inc;
    logic [DATA_W-1:0] cap_data;

    assign arb_en = (st_q == ST_IDLE);

    cache_arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_select (
        .clk_i     (CLK),
        .rst_ni    (Reset),
        .ireq_i    (bus.IReq),
        .dreq_i    (bus.DReq),
        .arb_en_i  (arb_en),
        .owner_o   (sel_owner),
        .any_req_o (any_req)
    );

    // Next state, transaction capture, watchdog and read-data capture.
    always_comb begin
        st_d     = st_q;
        owner_d  = owner_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        to_d     = to_q;
        wd_d     = wd_q;
        ird_d    = ird_q;
        drd_d    = drd_q;
        done     = we_q ? bus.CWriteReady : bus.CReadReady;
        wd_inc   = wd_q + WD_W'(1);
        cap_data = we_q ? '0 : bus.CRData;
        case (st_q)
            ST_IDLE: begin
                if (any_req) begin
                    owner_d = sel_owner;
                    to_d    = 1'b0;
                    st_d    = ST_ISSUE;
                    if (sel_owner == OWN_I) begin
                        addr_d  = bus.IAddr;
                        wdata_d = '0;
                        we_d    = 1'b0;
                    end else begin
                        addr_d  = bus.DAddr;
                        wdata_d = bus.DWData;
                        we_d    = bus.DWE;
                    end
                end
            end
            ST_ISSUE: begin
                wd_d = '0;
                st_d = ST_WAIT;
            end
            ST_WAIT: begin
                wd_d = wd_inc;
                if (done) begin
                    st_d = ST_RESP;
                    if (owner_q == OWN_I) begin
                        ird_d = cap_data;
                    end else begin
                        drd_d = cap_data;
                    end
                end else if (wd_inc == WD_W'(TIMEOUT)) begin
                    st_d = ST_RESP;
                    to_d = 1'b1;
                    if (owner_q == OWN_I) begin
                        ird_d = '0;
                    end else begin
                        drd_d = '0;
                    end
                end
            end
            ST_RESP: begin
                st_d = ST_IDLE;
            end
            default: begin
                st_d = ST_IDLE;
            end
        endcase
    end

    // State and transaction registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            st_q    <= ST_IDLE;
            owner_q <= OWN_I;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            to_q    <= 1'b0;
            wd_q    <= '0;
            ird_q   <= '0;
            drd_q   <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            to_q    <= to_d;
            wd_q    <= wd_d;
            ird_q   <= ird_d;
            drd_q   <= drd_d;
        end
    end

    // Outputs decode directly from registered state so reset clears them at once.
    assign bus.CStart       = (st_q == ST_ISSUE);
    assign bus.CWriteEnable = we_q && ((st_q == ST_ISSUE) || (st_q == ST_WAIT));
    assign bus.CAddr        = addr_q;
    assign bus.CWData       = wdata_q;
    assign bus.IGnt         = (st_q == ST_ISSUE) && (owner_q == OWN_I);
    assign bus.DGnt         = (st_q == ST_ISSUE) && (owner_q == OWN_D);
    assign bus.IValid       = (st_q == ST_RESP) && (owner_q == OWN_I);
    assign bus.DValid       = (st_q == ST_RESP) && (owner_q == OWN_D);
    assign bus.Timeout      = (st_q == ST_RESP) && to_q;
    assign bus.IRData       = ird_q;
    assign bus.DRData       = drd_q;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter: directed scenarios with literal
// expectations, then randomized requesters and cache against a
// transaction-level reference model compared every cycle.
module tb_cache_port_arbiter;

    localparam int unsigned AW   = 32;
    localparam int unsigned DW   = 32;
    localparam int unsigned SMAX = 4;
    localparam int unsigned TMO  = 8;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    cache_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cache_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .STARVE_MAX (SMAX),
        .TIMEOUT    (TMO)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: a transaction is described by its age k in cycles
    // since it was sampled (k=1 grant/issue, k>=2 waiting) and whether its
    // response has been decided.
    bit            m_busy;
    bit            m_own_d;
    bit            m_we;
    bit            m_resp;
    bit            m_to;
    int            m_k;
    int            m_starve;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_data, m_ird, m_drd;

    initial begin : model_cmp
        bit issue, waiting, resp, flag, win_i;
        m_busy = 0; m_starve = 0; m_resp = 0; m_k = 0;
        m_ird = '0; m_drd = '0;
        forever begin
            @(negedge CLK);
            if (!Reset) begin
                chk("rst_ctrl", {bus.IGnt, bus.IValid, bus.DGnt, bus.DValid,
                                 bus.CStart, bus.CWriteEnable, bus.Timeout}, 0);
                chk("rst_CAddr", bus.CAddr, 0);
                chk("rst_CWData", bus.CWData, 0);
                chk("rst_IRData", bus.IRData, 0);
                chk("rst_DRData", bus.DRData, 0);
                m_busy = 0; m_starve = 0; m_resp = 0;
                m_ird = '0; m_drd = '0;
            end else begin
                issue   = m_busy && (m_k == 1);
                waiting = m_busy && (m_k >= 2) && !m_resp;
                resp    = m_busy && m_resp;
                if (resp) begin
                    if (m_own_d) m_drd = m_data;
                    else         m_ird = m_data;
                end
                chk("IGnt",   bus.IGnt,   issue && !m_own_d);
                chk("DGnt",   bus.DGnt,   issue && m_own_d);
                chk("CStart", bus.CStart, issue);
                chk("CWE",    bus.CWriteEnable, (issue || waiting) && m_we);
                if (issue || waiting) begin
                    chk("CAddr", bus.CAddr, m_addr);
                    if (m_we) chk("CWData", bus.CWData, m_wdata);
                end
                chk("IValid",  bus.IValid,  resp && !m_own_d);
                chk("DValid",  bus.DValid,  resp && m_own_d);
                chk("Timeout", bus.Timeout, resp && m_to);
                chk("IRData",  bus.IRData,  m_ird);
                chk("DRData",  bus.DRData,  m_drd);

                // Advance to what the coming rising edge produces.
                if (!m_busy) begin
                    if (bus.IReq || bus.DReq) begin
                        win_i = bus.IReq && (!bus.DReq || m_starve == int'(SMAX));
                        if (win_i)         m_starve = 0;
                        else if (bus.IReq) m_starve = m_starve + 1;
                        m_own_d = !win_i;
                        m_addr  = win_i ? bus.IAddr : bus.DAddr;
                        m_wdata = win_i ? '0 : bus.DWData;
                        m_we    = win_i ? 1'b0 : bus.DWE;
                        m_busy  = 1; m_k = 1; m_resp = 0; m_to = 0;
                    end
                end else if (m_resp) begin
                    m_busy = 0;
                end else begin
                    if (m_k >= 2) begin
                        flag = m_we ? bus.CWriteReady : bus.CReadReady;
                        if (flag) begin
                            m_resp = 1; m_to = 0;
                            m_data = m_we ? '0 : bus.CRData;
                        end else if (m_k - 1 == int'(TMO)) begin
                            m_resp = 1; m_to = 1; m_data = '0;
                        end
                    end
                    m_k++;
                end
            end
        end
    end

    initial begin : stim
        string order;
        int    vcyc, gcyc;
        bit    quiet;
        bus.IReq = 0; bus.IAddr = '0; bus.DReq = 0; bus.DWE = 0;
        bus.DAddr = '0; bus.DWData = '0; bus.CRData = '0;
        bus.CReadReady = 0; bus.CWriteReady = 0;
        repeat (3) tick();
        chk("rst_lit_CStart", bus.CStart, 0);
        chk("rst_lit_IRData", bus.IRData, 0);
        Reset = 1;

        // I read, 3-cycle latency
        bus.IReq = 1; bus.IAddr = 32'h0;
        tick();
        chk("a_IGnt", bus.IGnt, 1);
        chk("a_CStart", bus.CStart, 1);
        bus.IReq = 0;
        tick();
        bus.CReadReady = 1; bus.CRData = 32'hE3A00001;
        tick();
        chk("a_IValid", bus.IValid, 1);
        chk("a_IRData", bus.IRData, 32'hE3A00001);
        bus.CReadReady = 0;
        tick();
        chk("a_IValid_off", bus.IValid, 0);
        chk("a_IRData_hold", bus.IRData, 32'hE3A00001);

        // D write, completes on 6th WAIT cycle, read-ready pulses ignored
        bus.DReq = 1; bus.DWE = 1; bus.DAddr = 32'h4; bus.DWData = 32'h12345678;
        tick();
        chk("b_DGnt", bus.DGnt, 1);
        bus.DReq = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("b_CWE", bus.CWriteEnable, 1);
            chk("b_CAddr", bus.CAddr, 32'h4);
            chk("b_CWData", bus.CWData, 32'h12345678);
            chk("b_DValid_wait", bus.DValid, 0);
            bus.CReadReady  = (i % 2 == 0);
            bus.CWriteReady = (i == 5);
        end
        tick();
        chk("b_DValid", bus.DValid, 1);
        chk("b_DRData", bus.DRData, 0);
        chk("b_Timeout", bus.Timeout, 0);
        bus.CReadReady = 0; bus.CWriteReady = 0;
        tick();
        chk("b_DValid_off", bus.DValid, 0);

        // Contention: order D,D,D,D,I repeating
        bus.CReadReady = 1; bus.CRData = 32'h0BADBEEF; bus.DWE = 0;
        bus.IReq = 1; bus.DReq = 1;
        order = "";
        for (int c = 0; c < 60 && order.len() < 10; c++) begin
            tick();
            if (bus.IGnt) order = {order, "I"};
            if (bus.DGnt) order = {order, "D"};
        end
        bus.IReq = 0; bus.DReq = 0;
        n_checks++;
        if (order != "DDDDIDDDDI") begin
            n_fail++;
            $display("FAIL c_order: got %s expected DDDDIDDDDI", order);
        end
        repeat (4) tick();
        bus.CReadReady = 0;

        // Watchdog on a D read with no ready flag
        bus.DReq = 1; bus.DWE = 0; bus.DAddr = 32'h100;
        tick();
        chk("d_DGnt", bus.DGnt, 1);
        bus.DReq = 0;
        chk("d_DRData_before", bus.DRData, 32'h0BADBEEF);
        for (int i = 0; i < int'(TMO); i++) begin
            tick();
            chk("d_noValid", bus.DValid, 0);
        end
        tick();
        chk("d_DValid", bus.DValid, 1);
        chk("d_Timeout", bus.Timeout, 1);
        chk("d_DRData", bus.DRData, 0);
        tick();
        chk("d_Timeout_off", bus.Timeout, 0);

        // Reset asserted mid-WAIT
        bus.IReq = 1; bus.IAddr = 32'h40;
        tick();
        bus.IReq = 0;
        tick();
        #2 Reset = 0;
        #1;
        chk("e_ctrl", {bus.IGnt, bus.IValid, bus.CStart, bus.CWriteEnable, bus.Timeout}, 0);
        chk("e_CAddr", bus.CAddr, 0);
        chk("e_IRData", bus.IRData, 0);
        tick();
        tick();
        Reset = 1;
        bus.IReq = 1; bus.IAddr = 32'h44;
        tick();
        chk("e_IGnt", bus.IGnt, 1);
        bus.IReq = 0;
        tick();
        bus.CReadReady = 1; bus.CRData = 32'hCAFEF00D;
        tick();
        chk("e_IValid", bus.IValid, 1);
        chk("e_IRData", bus.IRData, 32'hCAFEF00D);
        bus.CReadReady = 0;
        tick();

        // Late D request while I is in WAIT
        bus.IReq = 1; bus.IAddr = 32'h8;
        tick();
        bus.IReq = 0;
        tick();
        bus.DReq = 1; bus.DWE = 0; bus.DAddr = 32'h200;
        tick();
        chk("f_DGnt_early", bus.DGnt, 0);
        bus.CReadReady = 1; bus.CRData = 32'h55AA55AA;
        vcyc = -100; gcyc = -1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.IValid) vcyc = i;
            if (bus.DGnt) begin
                gcyc = i;
                break;
            end
        end
        bus.DReq = 0;
        chk("f_gap", 64'(gcyc - vcyc), 64'd2);
        repeat (4) tick();
        bus.CReadReady = 0;

        // Randomized traffic against the model
        quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 100 == 0) quiet = ($urandom_range(0, 2) == 0);
            bus.CReadReady  = !quiet && ($urandom_range(0, 3) == 0);
            bus.CWriteReady = !quiet && ($urandom_range(0, 3) == 0);
            bus.CRData      = $urandom;
            if (bus.IGnt) begin
                bus.IReq = ($urandom_range(0, 2) == 0);
                bus.IAddr = $urandom;
            end else if (!bus.IReq) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.IReq = 1; bus.IAddr = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                bus.IReq = 0;
            end
            if (bus.DGnt || !bus.DReq) begin
                if (bus.DGnt) bus.DReq = ($urandom_range(0, 2) == 0);
                else          bus.DReq = ($urandom_range(0, 3) == 0);
                bus.DWE    = $urandom_range(0, 1);
                bus.DAddr  = $urandom;
                bus.DWData = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                bus.DReq = 0;
            end
            tick();
        end
        bus.IReq = 0; bus.DReq = 0;
        bus.CReadReady = 0; bus.CWriteReady = 0;
        repeat (TMO + 6) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cache_port_arbiter.md
# cache_port_arbiter

Sequencer and two-port arbiter in front of the single `AssociativeCache4Way`, sharing it between the instruction-fetch (I) and data-memory (D) requesters of the ARM core. It picks a winner, drives the cache `Start`/`RWAddr`/`WriteData`/`WriteEnable` controls for exactly one transaction, and waits on the cache ready flags. It returns the result to the owning requester with a one-cycle valid pulse. It also provides starvation protection for I and a watchdog timeout.

## Interface

**Parameters**
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `STARVE_MAX`, default 4: number of consecutive contested D wins after which I is forced to win.
- `TIMEOUT`, default 255: maximum number of cycles spent in WAIT before the transaction is aborted.

**Ports**
- `CLK`  in  1: the single clock. All logic is rising-edge.
- `Reset`  in  1: asynchronous, active-low reset. Asserted when 0.
- `IReq`  in  1: instruction read request. Level; hold until `IGnt`.
- `IAddr`  in  ADDR_W: instruction address.
- `IGnt`  out  1: one-cycle pulse when the I request is accepted.
- `IValid`  out  1: one-cycle pulse when `IRData` is valid.
- `IRData`  out  DATA_W: instruction read data.
- `DReq`  in  1: data request. Level; hold until `DGnt`.
- `DWE`  in  1: data operation select, 1 = write, 0 = read.
- `DAddr`  in  ADDR_W: data address.
- `DWData`  in  DATA_W: data write value.
- `DGnt`  out  1: one-cycle pulse when the D request is accepted.
- `DValid`  out  1: one-cycle pulse that completes the D transaction, read or write.
- `DRData`  out  DATA_W: data read value.
- `CStart`  out  1: to cache `Start`.
- `CWriteEnable`  out  1: to cache `WriteEnable`.
- `CAddr`  out  ADDR_W: to cache `RWAddr`.
- `CWData`  out  DATA_W: to cache `WriteData`.
- `CRData`  in  DATA_W: from cache `ReadData`.
- `CReadReady`  in  1: from cache `ReadReady`.
- `CWriteReady`  in  1: from cache `WriteReady`.
- `Timeout`  out  1: one-cycle pulse, coincident with the Valid pulse of an aborted transaction.

## Operation

**State machine (`st`)**
- IDLE
  - Samples `IReq`/`DReq`.
  - If either request is high, the winner's `Addr`, `WData` and `WE` are registered; I always has `WE` = 0.
  - The owner is recorded and the machine goes to ISSUE.
- ISSUE (1 cycle)
  - `CStart` = 1, and the owner's `Gnt` = 1.
  - `CAddr`/`CWData`/`CWriteEnable` are driven from the registered fields.
  - Cache ready flags are ignored in this state.
  - Goes to WAIT.
- WAIT
  - `CStart` = 0. `CAddr`/`CWData`/`CWriteEnable` are held stable.
  - The completion flag is `CWriteReady` if the registered `WE` = 1, otherwise `CReadReady`. The non-matching flag is ignored.
  - On the completion flag: capture `CRData` for a read (writes return 0), then go to RESP.
  - The watchdog counter increments each WAIT cycle. When it reaches `TIMEOUT` with no completion flag: data = 0, set the `Timeout` flag, go to RESP.
- RESP (1 cycle)
  - The owner's `Valid` = 1 and `RData` = captured data. `Timeout` is pulsed if it was set.
  - Goes to IDLE.

**Arbitration (contested = both requests high in IDLE)**
- D wins a contested arbitration unless `starve_cnt` == `STARVE_MAX`, in which case I wins.
- `starve_cnt` increments on each contested D win, saturating at `STARVE_MAX`.
- `starve_cnt` clears whenever I is granted.
- An uncontested request always wins.

**Rules**
- `IRData`/`DRData` hold their last value between Valid pulses.
- A request that drops before being sampled in IDLE is never served. Once it has been sampled, the transaction always completes.
- Requests arriving during ISSUE/WAIT/RESP wait for the next IDLE.
- Reset values:
  - `st` = IDLE.
  - All outputs 0: every `Gnt`/`Valid`/`CStart`/`CWriteEnable`/`Timeout`, plus `CAddr`, `CWData` and both RData outputs.
  - `starve_cnt` = 0, watchdog counter = 0.
- Reset asserted mid-transaction aborts it: no `Valid` is issued and the cache controls drop to 0 immediately.

## Timing

- Request first sampled at edge N → ISSUE (`Gnt`, `CStart`) in cycle N+1.
- With the cache flag high in the first WAIT cycle (N+2), `Valid` occurs in cycle N+3. Minimum latency is 3 cycles.
- Back-to-back throughput: one transaction every 4 cycles minimum, because IDLE always occupies one cycle.
- The watchdog counter is cleared on entry to WAIT. A timeout `Valid` occurs `TIMEOUT`+1 cycles after ISSUE.
- The counter width is `$clog2(TIMEOUT+1)` and it never wraps.

## Structure

- Package `cache_arb_pkg`:
  - state encoding (IDLE/ISSUE/WAIT/RESP);
  - owner encoding (OWN_I/OWN_D);
  - width constant for the watchdog counter.
- One sub-module, `cache_arb_select`: winner selection plus the `starve_cnt` register. It takes `IReq`, `DReq` and an arbitration enable (high in IDLE), and outputs `owner` and `any_req`.
- The main module holds the FSM, the transaction registers and the watchdog.

## Test plan

- **Read, I only:** `IReq`=1, `IAddr`=0x00000000, `CReadReady` high in the first WAIT cycle with `CRData`=0xE3A00001 → `IGnt` and `CStart` in cycle 1; `IValid` in cycle 3 with `IRData`=0xE3A00001.
- **Write, D only:** `DReq`=1, `DWE`=1, `DAddr`=0x4, `DWData`=0x12345678, `CWriteReady` after 5 WAIT cycles → `CWriteEnable`/`CAddr`/`CWData` stable throughout WAIT; one `DValid` pulse; `CReadReady` pulses during WAIT are ignored.
- **Contention and starvation:** `IReq` and `DReq` held high continuously with `STARVE_MAX`=4 → grant order D,D,D,D,I, then the pattern repeats.
- **Watchdog:** D read with no ready flag and `TIMEOUT`=8 → `DValid` and `Timeout` together 9 cycles after ISSUE, `DRData`=0; the next request is served normally.
- **Reset mid-WAIT:** `Reset`=0 during WAIT → all outputs 0 asynchronously and no `Valid`; after release, a new `IReq` completes with 3-cycle latency.
- **Late requests:** `DReq` asserted while an I transaction is in WAIT → served only after the I `RESP`; `DGnt` appears exactly 2 cycles after `IValid` (IDLE, then ISSUE).
